// File: rtl/polygon_winding.sv
// Point-in-polygon test: walks one polygon edge per cycle and accumulates the winding number.
// Define POLYGON_EVEN_ODD_EN for the even-odd fill rule; the default build uses nonzero.
module polygon_winding #(
  parameter int PIXEL_WIDTH      = 1280,
  parameter int PIXEL_HEIGHT     = 720,
  parameter int MAX_NUM_VERTICES = 8,
  parameter int COORD_WIDTH      = 32
) (
  input  logic                                                clk_in,
  input  logic                                                rst_in,
  input  logic [$clog2(PIXEL_WIDTH)-1:0]                      hcount_in,
  input  logic [$clog2(PIXEL_HEIGHT)-1:0]                     vcount_in,
  input  logic [MAX_NUM_VERTICES-1:0][COORD_WIDTH-1:0]        xs_in,
  input  logic [MAX_NUM_VERTICES-1:0][COORD_WIDTH-1:0]        ys_in,
  input  logic [$clog2(MAX_NUM_VERTICES+1)-1:0]               num_vertices_in,
  input  logic                                                valid_in,
  output logic                                                ready_out,
  output logic                                                out,
  output logic signed [$clog2(MAX_NUM_VERTICES)+1:0]          winding_out,
  output logic                                                valid_out,
  input  logic                                                ready_in
);
  localparam int M  = MAX_NUM_VERTICES;
  localparam int CW = COORD_WIDTH;
  localparam int LW = 2*COORD_WIDTH+2;
  localparam int HW = $clog2(PIXEL_WIDTH);
  localparam int VW = $clog2(PIXEL_HEIGHT);
  localparam int NW = $clog2(MAX_NUM_VERTICES+1);
  localparam int KW = $clog2(MAX_NUM_VERTICES);
  localparam int WW = $clog2(MAX_NUM_VERTICES)+2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [HW-1:0]            px_q;
  logic [VW-1:0]            py_q;
  logic [M-1:0][CW-1:0]     xs_q, ys_q;
  logic [NW-1:0]            n_q, n_in;
  logic [KW-1:0]            k, k_nx;
  logic signed [WW-1:0]     acc, acc_nx, step;
  logic signed [CW:0]       px, py, xi, yi, xj, yj;
  logic signed [LW-1:0]     lval;
  logic                     accept, short_poly, last, lpos, lneg, up, dn;

  function automatic logic fill(input logic signed [WW-1:0] w);
`ifdef POLYGON_EVEN_ODD_EN
    return w[0];
`else
    return |w;
`endif
  endfunction

  assign n_in       = (num_vertices_in > NW'(M)) ? NW'(M) : num_vertices_in;
  assign short_poly = n_in < NW'(3);
  assign accept     = valid_in && ready_out;
  assign ready_out  = (state == IDLE);
  assign valid_out  = (state == DONE);

  // Wrap goes back to vertex 0 after the last active vertex, not after the array end.
  assign last = (NW'(k) == n_q - NW'(1));
  assign k_nx = last ? '0 : k + KW'(1);

  assign px = $signed((CW+1)'(px_q));
  assign py = $signed((CW+1)'(py_q));
  assign xi = (CW+1)'($signed(xs_q[k]));
  assign yi = (CW+1)'($signed(ys_q[k]));
  assign xj = (CW+1)'($signed(xs_q[k_nx]));
  assign yj = (CW+1)'($signed(ys_q[k_nx]));

  // Differences fit in CW+1 bits; products are formed at full width so the sign is exact.
  assign lval = LW'(xj - xi) * LW'(py - yi) - LW'(px - xi) * LW'(yj - yi);
  assign lneg = lval[LW-1];
  assign lpos = !lval[LW-1] && (lval != '0);
  assign up   = (yi <= py) && (yj > py) && lpos;
  assign dn   = (yi > py) && (yj <= py) && lneg;

  always_comb begin
    step = '0;
    if (up)      step = WW'(1);
    else if (dn) step = '1;
  end
  assign acc_nx = acc + step;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid_in) state_nx = short_poly ? DONE : RUN;
      RUN:     if (last)     state_nx = DONE;
      DONE:    if (ready_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      k           <= '0;
      acc         <= '0;
      winding_out <= '0;
      out         <= 1'b0;
    end else if (accept) begin
      px_q <= hcount_in;
      py_q <= vcount_in;
      xs_q <= xs_in;
      ys_q <= ys_in;
      n_q  <= n_in;
      k    <= '0;
      acc  <= '0;
      if (short_poly) begin
        winding_out <= '0;
        out         <= 1'b0;
      end
    end else if (state == RUN) begin
      acc <= acc_nx;
      k   <= k_nx;
      if (last) begin
        winding_out <= acc_nx;
        out         <= fill(acc_nx);
      end
    end
  end
endmodule

// File: tb/tb_polygon_winding.sv
// Directed bench for polygon_winding: vector table plus hold, input-change and reset-abort sequences.
module tb_polygon_winding;
  localparam int M  = 8;
  localparam int CW = 32;
`ifdef POLYGON_EVEN_ODD_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic [10:0]            hcount_in;
  logic [9:0]             vcount_in;
  logic [M-1:0][CW-1:0]   xs_in, ys_in;
  logic [3:0]             num_vertices_in;
  logic                   valid_in, ready_in;
  logic                   ready_out, out, valid_out;
  logic signed [4:0]      winding_out;

  int total = 0;
  int bad   = 0;

  polygon_winding dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .xs_in(xs_in), .ys_in(ys_in), .num_vertices_in(num_vertices_in), .valid_in(valid_in),
    .ready_out(ready_out), .out(out), .winding_out(winding_out), .valid_out(valid_out),
    .ready_in(ready_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string nm;
    int    px, py, n;
    int    xs[8];
    int    ys[8];
    int    wind;
    int    o;
    int    lat;
  } vec_t;

  int sq_x[8]  = '{100, 200, 200, 100, 0, 0, 0, 0};
  int sq_y[8]  = '{100, 100, 200, 200, 0, 0, 0, 0};
  int sqr_x[8] = '{100, 100, 200, 200, 0, 0, 0, 0};
  int sqr_y[8] = '{100, 200, 200, 100, 0, 0, 0, 0};
  int pg_x[8]  = '{320, 380, 230, 410, 260, 0, 0, 0};
  int pg_y[8]  = '{100, 280, 170, 170, 280, 0, 0, 0};
  int gb_x[8]  = '{100, 200, 200, 100, 500, -7, 123456, 500};
  int gb_y[8]  = '{100, 100, 200, 200, 0, 9999, -5, 0};
  int tri_x[8] = '{0, 300, 0, 0, 0, 0, 0, 0};
  int tri_y[8] = '{0, 0, 300, 0, 0, 0, 0, 0};
  int oct_x[8] = '{100, 150, 200, 200, 200, 150, 100, 100};
  int oct_y[8] = '{100, 100, 100, 150, 200, 200, 200, 150};

  localparam int NV = 11;
  vec_t tv[NV];

  function automatic vec_t mk(input string nm, input int px, input int py, input int n,
                              input int xs[8], input int ys[8], input int w, input int o,
                              input int lat);
    vec_t v;
    v.nm = nm; v.px = px; v.py = py; v.n = n;
    v.xs = xs; v.ys = ys; v.wind = w; v.o = o; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    hcount_in       = 11'(v.px);
    vcount_in       = 10'(v.py);
    num_vertices_in = 4'(v.n);
    for (int i = 0; i < M; i++) begin
      xs_in[i] = v.xs[i];
      ys_in[i] = v.ys[i];
    end
  endtask

  // Count cycles until valid_out, sampled on negedges; capped so a stuck DUT cannot hang the run.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk_in);
      lat++;
      if (valid_out) break;
    end
  endtask

  task automatic query(input vec_t v, input logic rdy, output int lat);
    @(negedge clk_in);
    load(v);
    valid_in = 1'b1;
    ready_in = rdy;
    chk({v.nm, " ready_out"}, int'(ready_out), 1);
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    wait_valid(lat);
  endtask

  initial begin
    int lat;
    tv[0]  = mk("sq_in",      150, 150, 4,  sq_x,  sq_y,  1,  1, 5);
    tv[1]  = mk("sq_out",     250, 150, 4,  sq_x,  sq_y,  0,  0, 5);
    tv[2]  = mk("sq_left",     50, 150, 4,  sq_x,  sq_y,  0,  0, 5);
    tv[3]  = mk("sqr_in",     150, 150, 4,  sqr_x, sqr_y, -1, 1, 5);
    tv[4]  = mk("sqr_out",    250, 150, 4,  sqr_x, sqr_y, 0,  0, 5);
    tv[5]  = mk("star",       320, 200, 5,  pg_x,  pg_y,  2,  EO ? 0 : 1, 6);
    tv[6]  = mk("garbage",    150, 150, 4,  gb_x,  gb_y,  1,  1, 5);
    tv[7]  = mk("n2",         150, 150, 2,  sq_x,  sq_y,  0,  0, 1);
    tv[8]  = mk("n0",         150, 150, 0,  sq_x,  sq_y,  0,  0, 1);
    tv[9]  = mk("tri",         50,  50, 3,  tri_x, tri_y, 1,  1, 4);
    tv[10] = mk("oct_clamp",  150, 130, 15, oct_x, oct_y, 1,  1, 9);

    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    load(tv[0]);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst ready_out", int'(ready_out), 1);
    chk("rst valid_out", int'(valid_out), 0);
    chk("rst out",       int'(out), 0);
    chk("rst winding",   int'(winding_out), 0);

    for (int i = 0; i < NV; i++) begin
      query(tv[i], 1'b1, lat);
      chk({tv[i].nm, " latency"}, lat, tv[i].lat);
      chk({tv[i].nm, " winding"}, int'(winding_out), tv[i].wind);
      chk({tv[i].nm, " out"},     int'(out), tv[i].o);
      @(negedge clk_in);
      chk({tv[i].nm, " back idle"}, int'(ready_out), 1);
      chk({tv[i].nm, " valid low"}, int'(valid_out), 0);
    end

    // Backpressure in DONE, with inputs scrambled and valid_in held while the query runs.
    @(negedge clk_in);
    load(tv[0]);
    valid_in = 1'b1;
    ready_in = 1'b0;
    @(posedge clk_in);
    #1 load(tv[1]);
    num_vertices_in = 4'd2;
    wait_valid(lat);
    chk("hold latency", lat, 5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      chk("hold valid_out", int'(valid_out), 1);
      chk("hold ready_out", int'(ready_out), 0);
      chk("hold winding",   int'(winding_out), 1);
      chk("hold out",       int'(out), 1);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk_in);
    chk("release ready_out", int'(ready_out), 1);
    chk("release valid_out", int'(valid_out), 0);
    chk("release keeps winding", int'(winding_out), 1);

    // Reset in the second RUN cycle must abort without a result.
    @(negedge clk_in);
    load(tv[3]);
    valid_in = 1'b1;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("abort ready_out", int'(ready_out), 1);
    chk("abort valid_out", int'(valid_out), 0);
    chk("abort winding",   int'(winding_out), 0);
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk_in);
        if (valid_out) seen++;
      end
      chk("abort no valid", seen, 0);
    end
    query(tv[0], 1'b1, lat);
    chk("post-abort latency", lat, 5);
    chk("post-abort winding", int'(winding_out), 1);
    chk("post-abort out",     int'(out), 1);

    @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
